// File: rtl/data_memory.sv
// Fixed-latency 256-bit line memory: a request is accepted in IDLE and
// acknowledged for exactly one cycle, LATENCY cycles after the accepting edge.
module data_memory #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [IDX_W-1:0] line;
  logic             unused_addr;

  reg [255:0] memory [0:DEPTH-1];

  // Line-aligned access: byte offset and bits above the array alias away.
  assign line        = addr_i[5 +: IDX_W];
  assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

  assign ack_o  = (state == BUSY) && (count == LAST);
  assign data_o = memory[line];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        count_next = '0;
        if (enable_i) state_next = BUSY;
      end
      BUSY: begin
        if (count == LAST) begin
          state_next = IDLE;
          count_next = '0;
        end else begin
          count_next = count + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // NOTE: the array is deliberately left out of reset; contents survive
  // rst_i, and ack_o is low during reset so an abandoned write never lands.
  always_ff @(posedge clk_i) begin
    if (ack_o && write_i) memory[line] <= data_i;
  end

  ack_single_cycle : assert property (
    @(posedge clk_i) disable iff (!rst_i) ack_o |=> !ack_o
  );

  ack_only_busy : assert property (
    @(posedge clk_i) disable iff (!rst_i) ack_o |-> (state == BUSY)
  );

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: ack timing, read/write data, aliasing,
// reset abandonment of a write, and back-to-back request spacing.
module tb_data_memory;

  localparam int LATENCY = 10;
  localparam int DEPTH   = 512;

  localparam logic [255:0] V0   = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
  localparam logic [255:0] A5   = {32{8'hA5}};
  localparam logic [255:0] ECFA = {16{16'hECFA}};
  localparam logic [255:0] M17  = {16{16'h1111}};
  localparam logic [255:0] DEAD = {8{32'hDEAD_BEEF}};

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [31:0]  addr_i = '0;
  logic [255:0] data_i = '0;
  logic         enable_i = 1'b0;
  logic         write_i = 1'b0;
  logic         ack_o;
  logic [255:0] data_o;

  int errors = 0;
  int checks = 0;

  data_memory #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .enable_i(enable_i),
    .write_i (write_i),
    .ack_o   (ack_o),
    .data_o  (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Accepts at E0, then checks ack after each edge E0..E10. At the ack cycle a
  // read checks data_o; a write checks the line is still its old value.
  task automatic txn(input string name, input logic [31:0] a, input logic [255:0] d,
                     input logic w, input logic [255:0] exp, input logic wiggle);
    logic [8:0] idx;
    idx      = a[13:5];
    addr_i   = a;
    data_i   = d;
    write_i  = w;
    enable_i = 1'b1;
    step();
    enable_i = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      check($sformatf("%s ack k=%0d", name, k), 256'(ack_o), 256'(k == 9));
      if (k == 9) begin
        if (w) check($sformatf("%s mem before ack", name), dut.memory[idx], exp);
        else   check($sformatf("%s rd data", name), data_o, exp);
      end
      if (k < 10) begin
        if (wiggle && k < 8) enable_i = ~enable_i;
        step();
      end
    end
    enable_i = 1'b0;
    write_i  = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    dut.memory[0]  = V0;
    dut.memory[2]  = ECFA;
    dut.memory[17] = M17;

    // Reset state; data_o still follows the array during reset.
    check("reset ack", 256'(ack_o), 256'(0));
    check("reset data_o", data_o, V0);
    step();
    step();
    check("reset state", 256'(dut.state), 256'(0));
    rst_i = 1'b1;
    step();
    check("idle ack", 256'(ack_o), 256'(0));

    // Plain read of line 0.
    txn("rd0", 32'h0000_0000, '0, 1'b0, V0, 1'b0);

    // Write A5 to 0x0220 (line 17), then read it back.
    txn("wr17", 32'h0000_0220, A5, 1'b1, M17, 1'b0);
    check("wr17 mem after", dut.memory[17], A5);
    check("wr17 line 0 intact", dut.memory[0], V0);
    txn("rd17", 32'h0000_0220, '0, 1'b0, A5, 1'b0);

    // Aliased, unaligned address with enable toggling while busy.
    txn("alias", 32'h0000_4004, '0, 1'b0, V0, 1'b1);
    check("alias idle", 256'(dut.state), 256'(0));

    // Reset at counter=5 abandons a write to 0x0040.
    addr_i   = 32'h0000_0040;
    data_i   = DEAD;
    write_i  = 1'b1;
    enable_i = 1'b1;
    step();
    enable_i = 1'b0;
    repeat (5) step();
    check("rst mid count", 256'(dut.count), 256'(5));
    rst_i = 1'b0;
    #1;
    check("rst mid ack", 256'(ack_o), 256'(0));
    check("rst mid state", 256'(dut.state), 256'(0));
    check("rst mid count clr", 256'(dut.count), 256'(0));
    check("rst data_o", data_o, ECFA);
    repeat (6) step();
    check("rst mem2", dut.memory[2], ECFA);
    rst_i   = 1'b1;
    write_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("post rst ack k=%0d", k), 256'(ack_o), 256'(0));
      step();
    end
    check("post rst mem2", dut.memory[2], ECFA);
    check("post rst mem0", dut.memory[0], V0);
    check("post rst mem17", dut.memory[17], A5);

    // Back-to-back reads with enable held: acks at k=9 and k=20.
    addr_i   = 32'h0000_0220;
    write_i  = 1'b0;
    enable_i = 1'b1;
    step();
    for (int k = 0; k <= 22; k++) begin
      check($sformatf("b2b ack k=%0d", k), 256'(ack_o), 256'(k == 9 || k == 20));
      if (k == 9 || k == 20) check($sformatf("b2b data k=%0d", k), data_o, A5);
      if (k == 10) check("b2b idle gap", 256'(dut.state), 256'(0));
      if (k == 20) enable_i = 1'b0;
      step();
    end
    check("b2b final idle", 256'(dut.state), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter LATENCY, default 10: number of cycles from the accepting clock edge to the final ack cycle, inclusive.
REQ-002 SHALL have parameter DEPTH, default 512: number of 256-bit lines (16 KB total).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port addr_i, input, 32 bits: byte address; line index = addr_i[13:5].
REQ-006 SHALL have port data_i, input, 256 bits: write line data.
REQ-007 SHALL have port enable_i, input, 1 bit: request valid.
REQ-008 SHALL have port write_i, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port ack_o, output, 1 bit: transaction complete.
REQ-010 SHALL have port data_o, output, 256 bits: read line data.
REQ-011 SHALL hold the storage array as reg [255:0] memory[0:DEPTH-1], so benches can load and read it hierarchically.

Function
REQ-012 SHALL have a two-state FSM: IDLE and BUSY, plus a cycle counter sized for LATENCY-1.
REQ-013 In IDLE with enable_i=1 at a rising edge, SHALL go to BUSY and clear the counter to 0; with enable_i=0, SHALL stay in IDLE.
REQ-014 In BUSY, SHALL increment the counter at each rising edge while the counter < LATENCY-1.
REQ-015 SHALL drive ack_o combinationally = (state==BUSY) && (counter==LATENCY-1); for LATENCY=10, ack_o is high for exactly one cycle, in the 10th cycle after the accepting edge.
REQ-016 At the rising edge where ack_o=1, SHALL return to IDLE and clear the counter.
REQ-017 At that same edge, if write_i=1, SHALL write memory[addr_i[13:5]] <= data_i; no write occurs at any other time.
REQ-018 SHALL drive data_o combinationally = memory[addr_i[13:5]]; data_o is valid whenever ack_o=1 on a read.
REQ-019 SHALL ignore addr_i[4:0] (line-aligned access) and addr_i[31:14]; addresses alias modulo 16 KB.
REQ-020 The requester SHALL hold addr_i, data_i and write_i stable from acceptance through the ack cycle; the design SHALL not latch them.
REQ-021 enable_i changes while BUSY SHALL have no effect; the transaction always completes.
REQ-022 After a completion, the FSM SHALL spend at least one cycle in IDLE before accepting a new request.
REQ-023 Back-to-back requests: if enable_i is still high in that IDLE cycle, SHALL accept it at the next edge, giving a LATENCY+1 cycle request period.
REQ-024 ack_o SHALL never be high in IDLE, and SHALL never be high for two consecutive cycles.

Reset
REQ-025 While rst_i=0 (asynchronous, active-low), SHALL force state=IDLE and counter=0, giving ack_o=0 immediately.
REQ-026 Reset SHALL NOT clear the memory contents; a BUSY transaction interrupted by reset SHALL be abandoned with no write.
REQ-027 data_o SHALL keep reflecting memory[addr_i[13:5]] during reset.

Verification
REQ-028 Read: memory[0]=0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF, addr_i=0x0, read accepted at edge E0 -> ack_o high only between E9 and E10, with data_o equal to that value.
REQ-029 Write then read: write 0xA5…A5 (256 bits) to addr_i=0x0220 -> memory[17] unchanged before E10 and equal to 0xA5…A5 after E10; a subsequent read of 0x0220 returns 0xA5…A5 after 10 cycles.
REQ-030 Alias and offset: read of addr_i=0x4004 -> returns memory[0] contents (low 5 bits and bit 14 ignored).
REQ-031 Reset mid-operation: write to 0x0040 accepted, rst_i pulled low at counter=5 -> ack_o=0 at once, FSM in IDLE, memory[2] keeps ECFA…ECFA, other memory intact.
REQ-032 Back-to-back: enable_i held high for two reads -> ack pulses 11 cycles apart, each one cycle wide.
